// File: rtl/csr_trap_sched_pkg.sv
// Shared definitions for the csr trap/interrupt sequencer.
// Sits alongside the csr.vh SYSOP_* macros; only the values this block
// needs to generate on its own are defined here.
package csr_trap_sched_pkg;

   // "No operation" encoding presented to csr on idle cycles
   localparam logic [4:0] SYSOP_NONE = 5'b0_0000;

   // Machine interrupt cause codes (mcause[3:0] for interrupts)
   localparam logic [3:0] IRQ_MSI = 4'd3;
   localparam logic [3:0] IRQ_MTI = 4'd7;
   localparam logic [3:0] IRQ_MEI = 4'd11;

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } state_e;

   // One op as presented to csr
   typedef struct packed {
      logic [4:0]  op;
      logic [63:0] pc;
      logic [63:0] tval;
      logic [63:0] wdata;
   } csr_req_t;

   // Fixed priority MEI > MSI > MTI. Only called when at least one
   // enabled source is pending, so MTI is the fall-through case.
   function automatic logic [3:0] irq_cause(input logic mei, input logic msi);
      if (mei)
         return IRQ_MEI;
      else if (msi)
         return IRQ_MSI;
      else
         return IRQ_MTI;
   endfunction

endpackage

// File: rtl/csr_trap_sched_irq_sync.sv
// Flop-chain synchronizer for one asynchronous interrupt level line.
module irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   localparam int N = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

   logic [N-1:0] chain;

   // Shift the raw line in at bit 0; the oldest sample leaves at the top
   always_ff @(posedge clk) begin
      if (rst)
         chain <= '0;
      else
         chain <= N'({chain, d});
   end

   assign q = chain[N-1];

endmodule

// File: rtl/csr_trap_sched.sv
// Front-end sequencer for csr: picks the executing system op or an
// injected machine interrupt, holds the pipe and redirects fetch after
// any trap-class op, and enforces a post-trap interrupt holdoff.
module csr_trap_sched
   import csr_trap_sched_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [4:0]  ex_op,
   input  logic [63:0] ex_pc,
   input  logic [63:0] ex_tval,
   input  logic [63:0] ex_wdata,
   input  logic        irq_msip,
   input  logic        irq_mtip,
   input  logic        irq_meip,
   input  logic [63:0] csr_mie,
   input  logic        csr_mstatus_mie,
   output logic [4:0]  csr_op,
   output logic [63:0] csr_pc,
   output logic [63:0] csr_tval,
   output logic [63:0] csr_wdata,
   input  logic        csr_trap_en,
   input  logic [63:0] csr_trap_pc,
   output logic        redir_valid,
   output logic [63:0] redir_pc,
   input  logic        redir_ready,
   output logic        irq_taken
);

   localparam int              HW         = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
   localparam logic [HW-1:0]   HOLDOFF_LD = HW'(HOLDOFF);

   state_e        state;
   logic [HW-1:0] holdoff_cnt;
   logic          is_trap;

   logic sync_msip, sync_mtip, sync_meip;
   logic en_mei, en_msi, en_mti;
   logic pend;
   csr_req_t req;

   // Only the three machine-level enable bits matter here
   logic unused_mie;
   assign unused_mie = ^{csr_mie[63:12], csr_mie[10:8], csr_mie[6:4], csr_mie[2:0]};

   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_msip (
      .clk (clk), .rst (rst), .d (irq_msip), .q (sync_msip)
   );
   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mtip (
      .clk (clk), .rst (rst), .d (irq_mtip), .q (sync_mtip)
   );
   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_meip (
      .clk (clk), .rst (rst), .d (irq_meip), .q (sync_meip)
   );

   assign en_mei = sync_meip & csr_mie[11];
   assign en_msi = sync_msip & csr_mie[3];
   assign en_mti = sync_mtip & csr_mie[7];

   // Interrupts are only taken at an instruction boundary in RUN and once
   // the previous handler has retired enough instructions.
   assign pend = (en_mei | en_msi | en_mti) & csr_mstatus_mie &
                 (holdoff_cnt == '0) & (state == RUN);

   // Select what csr sees this cycle; an interrupt replaces the op entirely
   always_comb begin
      req       = '0;
      req.op    = SYSOP_NONE;
      ex_ready  = 1'b0;
      irq_taken = 1'b0;
      if (!rst && (state == RUN) && ex_valid) begin
         ex_ready = 1'b1;
         if (pend) begin
            // Instruction is dropped and replays after mret
            req.op    = {1'b1, irq_cause(en_mei, en_msi)};
            req.pc    = ex_pc;
            irq_taken = 1'b1;
         end else begin
            req.op    = ex_op;
            req.pc    = ex_pc;
            req.tval  = ex_tval;
            req.wdata = ex_wdata;
         end
      end
   end

   assign csr_op    = req.op;
   assign csr_pc    = req.pc;
   assign csr_tval  = req.tval;
   assign csr_wdata = req.wdata;

   // Trap sequencing: capture redirect target, hold until fetch accepts,
   // then arm the holdoff for exception/interrupt handlers only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         holdoff_cnt <= '0;
         is_trap     <= 1'b0;
         redir_valid <= 1'b0;
         redir_pc    <= '0;
      end else begin
         case (state)
            RUN: begin
               if (ex_valid) begin
                  if (pend) begin
                     redir_pc    <= csr_trap_pc;
                     is_trap     <= 1'b1;
                     redir_valid <= 1'b1;
                     state       <= TRAP;
                  end else if (csr_trap_en) begin
                     redir_pc    <= csr_trap_pc;
                     is_trap     <= ex_op[4];
                     redir_valid <= 1'b1;
                     state       <= TRAP;
                  end else if (holdoff_cnt != '0) begin
                     holdoff_cnt <= holdoff_cnt - HW'(1);
                  end
               end
            end
            TRAP: begin
               if (redir_ready) begin
                  redir_valid <= 1'b0;
                  holdoff_cnt <= is_trap ? HOLDOFF_LD : '0;
                  state       <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_trap_sched.sv
// Scoreboard bench for csr_trap_sched: stimulus pushes expected csr ops
// and redirects; a negedge monitor pops and compares them.
module tb_csr_trap_sched;

   localparam logic [4:0]  SYSOP_NONE  = 5'h00;
   localparam logic [4:0]  SYSOP_RET   = 5'h01;
   localparam logic [4:0]  SYSOP_CSR_W = 5'h02;
   localparam logic [4:0]  SYSOP_CSR_S = 5'h03;
   localparam logic [4:0]  EXC_OP      = 5'h12;
   localparam logic [63:0] TRAP_PC     = 64'h8000_0100;

   // step kinds
   localparam int K_NONE  = 0;  // nothing consumed
   localparam int K_PLAIN = 1;  // op passes through
   localparam int K_MSI   = 2;  // MSI injected
   localparam int K_MEI   = 3;  // MEI injected
   localparam int K_MEI_NR = 4; // MEI injected, redirect never accepted

   typedef struct {
      logic [4:0]  op;
      logic [63:0] pc;
      logic [63:0] tval;
      logic [63:0] wdata;
      logic        irq;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready;
   logic [4:0]  ex_op;
   logic [63:0] ex_pc, ex_tval, ex_wdata;
   logic        irq_msip, irq_mtip, irq_meip;
   logic [63:0] csr_mie;
   logic        csr_mstatus_mie;
   logic [4:0]  csr_op;
   logic [63:0] csr_pc, csr_tval, csr_wdata;
   logic        csr_trap_en;
   logic [63:0] csr_trap_pc;
   logic        redir_valid;
   logic [63:0] redir_pc;
   logic        redir_ready;
   logic        irq_taken;

   // shadow settings applied at the start of the next step
   logic        s_rst = 1'b1, s_mstat = 1'b0, s_msip = 1'b0, s_mtip = 1'b0, s_meip = 1'b0;
   logic [63:0] s_mie = '0;

   exp_t        exp_q[$];
   logic [63:0] redir_q[$];
   exp_t        mon_e;
   logic [63:0] mon_r;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   // Minimal csr model: exceptions, interrupts and RET request a trap
   assign csr_trap_en = csr_op[4] | (csr_op == SYSOP_RET);
   assign csr_trap_pc = TRAP_PC;

   csr_trap_sched #(.SYNC_STAGES(2), .HOLDOFF(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .ex_valid        (ex_valid),
      .ex_ready        (ex_ready),
      .ex_op           (ex_op),
      .ex_pc           (ex_pc),
      .ex_tval         (ex_tval),
      .ex_wdata        (ex_wdata),
      .irq_msip        (irq_msip),
      .irq_mtip        (irq_mtip),
      .irq_meip        (irq_meip),
      .csr_mie         (csr_mie),
      .csr_mstatus_mie (csr_mstatus_mie),
      .csr_op          (csr_op),
      .csr_pc          (csr_pc),
      .csr_tval        (csr_tval),
      .csr_wdata       (csr_wdata),
      .csr_trap_en     (csr_trap_en),
      .csr_trap_pc     (csr_trap_pc),
      .redir_valid     (redir_valid),
      .redir_pc        (redir_pc),
      .redir_ready     (redir_ready),
      .irq_taken       (irq_taken)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // One clock: apply inputs just after the edge, push expectations, and
   // return just after the following negedge (monitor has sampled).
   task automatic step(input logic v, input logic [4:0] op, input logic [63:0] pc,
                       input logic [63:0] tval, input logic [63:0] wdata,
                       input int kind, input logic rr);
      exp_t e;
      @(posedge clk);
      #1;
      rst = s_rst; csr_mstatus_mie = s_mstat; csr_mie = s_mie;
      irq_msip = s_msip; irq_mtip = s_mtip; irq_meip = s_meip;
      ex_valid = v; ex_op = op; ex_pc = pc; ex_tval = tval; ex_wdata = wdata;
      redir_ready = rr;
      if (kind == K_PLAIN) begin
         e = '{op: op, pc: pc, tval: tval, wdata: wdata, irq: 1'b0};
         exp_q.push_back(e);
         if (op[4] || op == SYSOP_RET) redir_q.push_back(TRAP_PC);
      end else if (kind != K_NONE) begin
         e = '{op: (kind == K_MSI) ? 5'b10011 : 5'b11011, pc: pc, tval: '0, wdata: '0, irq: 1'b1};
         exp_q.push_back(e);
         if (kind != K_MEI_NR) redir_q.push_back(TRAP_PC);
      end
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input logic rr);
      step(1'b0, SYSOP_NONE, '0, '0, '0, K_NONE, rr);
   endtask

   // Monitor: every consumed op and every accepted redirect is matched
   always @(negedge clk) begin
      if (ex_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL csr_unexpected: got op=%h pc=%h irq=%b, expected no op", csr_op, csr_pc, irq_taken);
         end else begin
            mon_e = exp_q.pop_front();
            if ({csr_op, csr_pc, csr_tval, csr_wdata, irq_taken} !==
                {mon_e.op, mon_e.pc, mon_e.tval, mon_e.wdata, mon_e.irq}) begin
               n_fail++;
               $display("FAIL csr_op: got op=%h pc=%h tval=%h wdata=%h irq=%b, expected op=%h pc=%h tval=%h wdata=%h irq=%b",
                        csr_op, csr_pc, csr_tval, csr_wdata, irq_taken,
                        mon_e.op, mon_e.pc, mon_e.tval, mon_e.wdata, mon_e.irq);
            end
         end
      end else if (ex_valid) begin
         n_tests++;
         if (csr_op !== SYSOP_NONE || irq_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL csr_idle: got op=%h irq=%b, expected op=00 irq=0", csr_op, irq_taken);
         end
      end
      if (redir_valid && redir_ready) begin
         n_tests++;
         if (redir_q.size() == 0) begin
            n_fail++;
            $display("FAIL redir_unexpected: got pc=%h, expected no redirect", redir_pc);
         end else begin
            mon_r = redir_q.pop_front();
            if (redir_pc !== mon_r) begin
               n_fail++;
               $display("FAIL redir_pc: got %h, expected %h", redir_pc, mon_r);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_pc = '0; ex_tval = '0; ex_wdata = '0;
      irq_msip = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b0;
      csr_mie = '0; csr_mstatus_mie = 1'b0; redir_ready = 1'b0;

      // Reset: outputs held quiet even with a valid instruction present
      step(1'b1, SYSOP_CSR_W, 64'h1000, 64'h305, 64'h1, K_NONE, 1'b0);
      step(1'b1, SYSOP_CSR_W, 64'h1000, 64'h305, 64'h1, K_NONE, 1'b0);
      chk("rst_ex_ready", {63'd0, ex_ready}, 64'd0);
      chk("rst_csr_op", {59'd0, csr_op}, 64'd0);
      chk("rst_csr_pc", csr_pc, 64'd0);
      chk("rst_irq_taken", {63'd0, irq_taken}, 64'd0);
      chk("rst_redir_valid", {63'd0, redir_valid}, 64'd0);
      chk("rst_redir_pc", redir_pc, 64'd0);
      s_rst = 1'b0;
      idle(1'b0);

      // Plain CSR write passes straight through
      step(1'b1, SYSOP_CSR_W, 64'h8000_0000, 64'h305, 64'h8000_0100, K_PLAIN, 1'b0);
      idle(1'b0);
      chk("plain_no_redir", {63'd0, redir_valid}, 64'd0);

      // Exception: redirect next cycle, pipe held until accepted.
      // MSI raised now so it is synchronized by the time the holdoff runs.
      s_mstat = 1'b1; s_mie = 64'h8; s_msip = 1'b1;
      step(1'b1, EXC_OP, 64'h8000_0040, 64'hBAD, 64'h0, K_PLAIN, 1'b0);
      step(1'b1, SYSOP_CSR_W, 64'h8000_0100, 64'h340, 64'h5, K_NONE, 1'b0);
      chk("exc_redir_valid", {63'd0, redir_valid}, 64'd1);
      chk("exc_redir_pc", redir_pc, TRAP_PC);
      step(1'b1, SYSOP_CSR_W, 64'h8000_0100, 64'h340, 64'h5, K_NONE, 1'b0);
      chk("exc_hold_ready", {63'd0, ex_ready}, 64'd0);
      step(1'b1, SYSOP_CSR_W, 64'h8000_0100, 64'h340, 64'h5, K_NONE, 1'b1);

      // Holdoff: four retire with MSI pending, fifth (a CSR write) is preempted
      for (int i = 0; i < 4; i++)
         step(1'b1, SYSOP_CSR_W, 64'h8000_0100 + 64'(4*i), 64'h340, 64'(i), K_PLAIN, 1'b0);
      chk("holdoff_no_redir", {63'd0, redir_valid}, 64'd0);
      step(1'b1, SYSOP_CSR_W, 64'h8000_0110, 64'h300, 64'hAA, K_MSI, 1'b0);
      s_msip = 1'b0;
      idle(1'b0);
      chk("msi_redir_valid", {63'd0, redir_valid}, 64'd1);
      idle(1'b0);
      idle(1'b1);
      for (int i = 0; i < 4; i++)
         step(1'b1, SYSOP_CSR_S, 64'h8000_0200 + 64'(4*i), 64'h341, 64'h0, K_PLAIN, 1'b0);

      // MTI and MEI together: two sync cycles, then MEI wins
      s_mie = 64'h888; s_mtip = 1'b1; s_meip = 1'b1;
      step(1'b1, SYSOP_CSR_W, 64'h8000_1000, 64'h305, 64'h7, K_PLAIN, 1'b0);
      step(1'b1, SYSOP_CSR_W, 64'h8000_1000, 64'h305, 64'h7, K_PLAIN, 1'b0);
      step(1'b1, SYSOP_CSR_W, 64'h8000_1000, 64'h305, 64'h7, K_MEI, 1'b0);
      s_mtip = 1'b0; s_meip = 1'b0;
      idle(1'b0);
      idle(1'b0);
      idle(1'b1);
      for (int i = 0; i < 4; i++)
         step(1'b1, SYSOP_CSR_W, 64'h8000_0300 + 64'(4*i), 64'h305, 64'h0, K_PLAIN, 1'b0);

      // Masked by mstatus.MIE, then unmasked against an exception
      s_mstat = 1'b0; s_msip = 1'b1; s_mtip = 1'b1; s_meip = 1'b1;
      idle(1'b0);
      idle(1'b0);
      step(1'b1, SYSOP_CSR_S, 64'h8000_0400, 64'h300, 64'h8, K_PLAIN, 1'b0);
      s_mstat = 1'b1;
      step(1'b1, EXC_OP, 64'h8000_0404, 64'hBAD, 64'h0, K_MEI_NR, 1'b0);

      // Reset while the redirect is outstanding
      s_rst = 1'b1; s_msip = 1'b0; s_mtip = 1'b0; s_meip = 1'b0;
      step(1'b1, SYSOP_CSR_W, 64'h8000_0500, 64'h305, 64'h1, K_NONE, 1'b0);
      chk("trap_redir_valid", {63'd0, redir_valid}, 64'd1);
      chk("midrst_csr_op", {59'd0, csr_op}, 64'd0);
      chk("midrst_ex_ready", {63'd0, ex_ready}, 64'd0);
      step(1'b1, SYSOP_CSR_W, 64'h8000_0500, 64'h305, 64'h1, K_NONE, 1'b0);
      chk("midrst_redir_valid", {63'd0, redir_valid}, 64'd0);
      chk("midrst_redir_pc", redir_pc, 64'd0);
      s_rst = 1'b0; s_mstat = 1'b0; s_mie = '0;
      step(1'b1, SYSOP_CSR_W, 64'h8000_0600, 64'h305, 64'h2, K_PLAIN, 1'b0);

      // RET redirects but leaves no holdoff: MSI injects right after
      step(1'b1, SYSOP_RET, 64'h8000_0604, 64'h0, 64'h0, K_PLAIN, 1'b0);
      s_mstat = 1'b1; s_mie = 64'h8; s_msip = 1'b1;
      idle(1'b0);
      idle(1'b0);
      idle(1'b1);
      step(1'b1, SYSOP_CSR_W, 64'h8000_0700, 64'h305, 64'h3, K_MSI, 1'b0);
      s_msip = 1'b0;
      idle(1'b0);
      idle(1'b1);
      idle(1'b0);

      n_tests++;
      if (exp_q.size() != 0 || redir_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d ops and %0d redirects outstanding, expected 0 and 0",
                  exp_q.size(), redir_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_trap_sched.md
Name: csr_trap_sched

Overview:
- Sequencing front-end for the csr unit. Sits between the execute stage and csr.
- Picks one system op per cycle for csr from two sources: the executing instruction's op, or an injected machine interrupt.
- After any trap-class op it holds the pipeline and drives a redirect to fetch. It enforces a post-trap interrupt holdoff so each handler makes forward progress.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each external irq line (min 1).
- HOLDOFF, 4, instructions that must retire after an exception/interrupt redirect before another interrupt is accepted. 0 disables the holdoff.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  instruction consumed this cycle
- ex_op  in  5  system op (csr.vh SYSOP_* encoding; bit4 = exception, [3:0] = cause)
- ex_pc  in  64  instruction pc
- ex_tval  in  64  csr address or trap value
- ex_wdata  in  64  csr write data
- irq_msip, irq_mtip, irq_meip  in  1 each  async level interrupt lines
- csr_mie  in  64  current mie from csr
- csr_mstatus_mie  in  1  mstatus.MIE from csr
- csr_op  out  5  op to csr
- csr_pc  out  64  pc to csr
- csr_tval  out  64  tval to csr
- csr_wdata  out  64  wdata to csr
- csr_trap_en  in  1  csr trap_en
- csr_trap_pc  in  64  csr trap_pc
- redir_valid  out  1  fetch redirect request
- redir_pc  out  64  redirect target
- redir_ready  in  1  fetch accepted redirect
- irq_taken  out  1  one-cycle pulse when an interrupt is injected

Behaviour:
- Reset (rst=1 at a clk edge): state=RUN, holdoff_cnt=0, all sync flops 0, redir_valid=0, redir_pc=0. While rst=1: csr_op=SYSOP_NONE (5'b0), csr_pc/tval/wdata=0, ex_ready=0, irq_taken=0.
- Reset mid-TRAP: the pending redirect is discarded.
- Synchronizers: each irq line passes through SYNC_STAGES flops. Latency from input to eligibility is SYNC_STAGES cycles.
- Interrupt enables, evaluated per cycle:
  - en_mei = sync_meip & csr_mie[11]
  - en_msi = sync_msip & csr_mie[3]
  - en_mti = sync_mtip & csr_mie[7]
- Interrupt gate: pend = (en_mei | en_msi | en_mti) & csr_mstatus_mie & (holdoff_cnt==0) & (state==RUN).
- Priority: MEI(11) > MSI(3) > MTI(7).
- State RUN:
  - ex_valid=0: csr_op=NONE, ex_ready=0.
  - ex_valid=1 & pend:
    - csr_op={1'b1, cause}, csr_pc=ex_pc, csr_tval=0, csr_wdata=0.
    - ex_ready=1: the instruction is dropped and re-executes after mret.
    - irq_taken=1; latch redir_pc<=csr_trap_pc; set is_trap flag; next state TRAP.
  - ex_valid=1 & !pend:
    - csr_op/pc/tval/wdata = ex_* combinationally; ex_ready=1.
    - If csr_trap_en: latch redir_pc<=csr_trap_pc; is_trap<=ex_op[4]; next state TRAP.
    - Else stay in RUN. If holdoff_cnt>0, decrement it (counts retired instructions).
- State TRAP:
  - csr_op=NONE, ex_ready=0, redir_valid=1, redir_pc stable.
  - On redir_ready: redir_valid<=0; holdoff_cnt<=is_trap ? HOLDOFF : 0; next state RUN.
- Redirect timing: redir_valid is registered, so it rises the cycle after the trap op. The earliest RUN re-entry is 2 cycles after the trap op.
- Simultaneous events:
  - irq pending and ex_op exception in the same cycle: interrupt wins, exception suppressed.
  - irq and CSR write in the same cycle: interrupt wins, write not issued.
  - The mie/mstatus change from a CSR write is seen by the interrupt gate on the following cycle, with no extra handling.
- SYSOP_RET and the csr invalid-satp trap also redirect via TRAP, but do not load the holdoff.
- csr_* outputs are pure functions of state and ex_*. Exactly one op reaches csr per cycle.

Decomposition:
- Shared package: SYSOP_NONE, interrupt cause constants (IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11), and the 2-state enum RUN/TRAP. These sit alongside the existing csr.vh SYSOP_* macros.
- One sub-module: irq_sync (parameterised SYNC_STAGES flop chain, synchronous active-high reset), instantiated once per line.

Test Plan:
- Plain CSR op:
  - Stimulus: ex_valid=1, ex_op=SYSOP_CSR_W, ex_tval=0x305, ex_wdata=0x80000100, no irq.
  - Response: csr_op=SYSOP_CSR_W, ex_ready=1 the same cycle, csr_trap_en=0, no redir_valid.
- Exception redirect:
  - Stimulus: ex_op={1,4'd2}, ex_pc=0x80000040, csr_trap_pc=0x80000100.
  - Response: redir_valid=1 next cycle with redir_pc=0x80000100, ex_ready=0 until redir_ready. Then holdoff_cnt=4.
- Interrupt injection and priority:
  - Stimulus: csr_mstatus_mie=1, csr_mie=0x888, irq_mtip and irq_meip rise together, ex_valid=1, ex_pc=0x80001000.
  - Response: after 2 sync cycles csr_op=5'b11011 (cause 11), csr_pc=0x80001000, irq_taken pulses.
- Holdoff:
  - Stimulus: after the redirect, hold irq_msip=1 with mie[3]=1.
  - Response: no injection until 4 instructions retire; the 5th valid cycle gets csr_op=5'b10011.
- Mask and collision:
  - Stimulus: csr_mstatus_mie=0, all irqs high, ex_op=SYSOP_CSR_S.
  - Response: CSR op passes, no injection. Then set MIE=1 with ex_op=exception: the interrupt wins and the exception does not reach csr.
- Reset mid-TRAP:
  - Stimulus: assert rst while redir_valid=1.
  - Response: next cycle redir_valid=0, redir_pc=0, state RUN, csr_op=NONE, ex_ready=0 while rst=1.
